// File: rtl/matrix_store.sv
// matrix_store: gathers parser element writes into matrices, commits them to a slot ring, streams them back
module matrix_store #(
  parameter int ELEM_W   = 8,
  parameter int MAX_DIM  = 5,
  parameter int NUM_SLOT = 8,
  parameter int ID_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  input  logic              wr_en,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic              wr_abort,
  input  logic              rd_req,
  input  logic [ID_W-1:0]   rd_id,
  output logic              commit,
  output logic [ID_W-1:0]   commit_id,
  output logic [ID_W:0]     mat_count,
  output logic              dim_err,
  output logic              rd_err,
  output logic              rd_valid,
  output logic [ELEM_W-1:0] rd_data,
  output logic              rd_last,
  output logic [2:0]        rd_dim_m,
  output logic [2:0]        rd_dim_n,
  output logic              busy
);
  localparam int SZ = MAX_DIM * MAX_DIM;
  localparam int AW = $clog2(NUM_SLOT * SZ);
  localparam int SW = $clog2(NUM_SLOT);
  typedef enum logic [1:0] {IDLE, WRITE, READ_SETUP, READ} state_t;
  state_t state, nxt;
  logic [ELEM_W-1:0] mem [NUM_SLOT*SZ];
  logic [ELEM_W-1:0] mem_q;
  logic [2:0] slot_m [NUM_SLOT];
  logic [2:0] slot_n [NUM_SLOT];
  logic [NUM_SLOT-1:0] valid;
  logic [ID_W-1:0] wr_ptr, rid;
  logic [SW-1:0] wsl, rsl;
  logic [4:0] total, idx, cur, rtotal, wtot, widx, rtot, icur;
  logic [2:0] dm, dn;
  logic [AW-1:0] waddr, raddr;
  logic pend, v1, l1, e1;
  logic dims_ok, start, wr_go, wr_done, rd_ok, iss, iss_last;
  assign busy = state != IDLE;
  always_comb begin
    wsl = SW'(wr_ptr);
    rsl = SW'(rid);
    dims_ok = dim_m != 3'd0 && dim_n != 3'd0 && int'(dim_m) <= MAX_DIM && int'(dim_n) <= MAX_DIM;
    start = state == IDLE && wr_en && dims_ok;
    wr_go = start || (state == WRITE && wr_en && !wr_abort);
    wtot = start ? 5'(dim_m) * 5'(dim_n) : total;
    widx = start ? 5'd0 : idx;
    wr_done = wr_go && widx == wtot - 5'd1;
    rd_ok = {1'b0, rid} < (ID_W+1)'(NUM_SLOT) && valid[rsl];
    rtot = state == READ ? rtotal : 5'(slot_m[rsl]) * 5'(slot_n[rsl]);
    icur = state == READ ? cur : 5'd0;
    iss = state == READ || (state == READ_SETUP && rd_ok);
    iss_last = iss && icur == rtot - 5'd1;
    waddr = AW'(wr_ptr) * AW'(SZ) + AW'(widx);
    raddr = AW'(rid) * AW'(SZ) + AW'(icur);
    nxt = state;
    if (state == IDLE || state == WRITE)
      nxt = (state == WRITE && wr_abort) ? IDLE :
            wr_done ? ((pend || rd_req) ? READ_SETUP : IDLE) :
            start ? WRITE :
            (state == IDLE && (pend || rd_req)) ? READ_SETUP : state;
    else
      nxt = (iss && !iss_last) ? READ : IDLE;
  end
  always_ff @(posedge clk) begin
    if (wr_go) mem[waddr] <= wr_data;
    if (iss) mem_q <= mem[raddr];
    if (wr_done) begin
      slot_m[wsl] <= start ? dim_m : dm;
      slot_n[wsl] <= start ? dim_n : dn;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      wr_ptr    <= '0;
      mat_count <= '0;
      commit    <= 1'b0;
      commit_id <= '0;
      dim_err   <= 1'b0;
      rd_err    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      rd_dim_m  <= '0;
      rd_dim_n  <= '0;
      pend      <= 1'b0;
      rid       <= '0;
      total     <= '0;
      idx       <= '0;
      cur       <= '0;
      rtotal    <= '0;
      dm        <= '0;
      dn        <= '0;
      v1        <= 1'b0;
      l1        <= 1'b0;
      e1        <= 1'b0;
    end else begin
      state    <= nxt;
      commit   <= wr_done;
      dim_err  <= state == IDLE && wr_en && !dims_ok;
      v1       <= iss;
      l1       <= iss_last;
      e1       <= state == READ_SETUP && !rd_ok;
      rd_valid <= v1;
      rd_last  <= l1;
      rd_err   <= e1;
      if (v1) rd_data <= mem_q;
      // only the newest request is held; it is resolved once the FSM reaches READ_SETUP
      if (rd_req && (state == IDLE || state == WRITE)) begin
        pend <= 1'b1;
        rid  <= rd_id;
      end else if (state == READ_SETUP) pend <= 1'b0;
      if (start) begin
        total      <= wtot;
        dm         <= dim_m;
        dn         <= dim_n;
        valid[wsl] <= 1'b0;
      end
      if (wr_go) idx <= widx + 5'd1;
      if (wr_done) begin
        valid[wsl] <= 1'b1;
        commit_id  <= wr_ptr;
        wr_ptr     <= wr_ptr == ID_W'(NUM_SLOT-1) ? '0 : wr_ptr + ID_W'(1);
        if (mat_count != (ID_W+1)'(NUM_SLOT)) mat_count <= mat_count + (ID_W+1)'(1);
      end
      if (state == READ_SETUP && rd_ok) begin
        rd_dim_m <= slot_m[rsl];
        rd_dim_n <= slot_n[rsl];
        rtotal   <= rtot;
      end
      cur <= icur + 5'd1;
    end
  end
endmodule

// File: tb/tb_matrix_store.sv
// tb_matrix_store: randomized scoreboard bench for matrix_store against a slot-array reference model
module tb_matrix_store;
  logic clk = 0, rst_n = 0;
  logic [2:0] dim_m = 0, dim_n = 0, rd_id = 0;
  logic [3:0] rd_id2 = 0;
  logic wr_en = 0, wr_abort = 0, rd_req = 0, rd_req2 = 0;
  logic [7:0] wr_data = 0;
  logic commit, dim_err, rd_err, rd_valid, rd_last, busy;
  logic [2:0] commit_id, rd_dim_m, rd_dim_n;
  logic [3:0] mat_count;
  logic [7:0] rd_data;
  logic commit2, dim_err2, rd_err2, rd_valid2, rd_last2, busy2;
  logic [3:0] commit_id2;
  logic [4:0] mat_count2;
  logic [2:0] rd_dim_m2, rd_dim_n2;
  logic [7:0] rd_data2;

  matrix_store dut (
    .clk(clk), .rst_n(rst_n), .dim_m(dim_m), .dim_n(dim_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_abort(wr_abort), .rd_req(rd_req), .rd_id(rd_id), .commit(commit), .commit_id(commit_id),
    .mat_count(mat_count), .dim_err(dim_err), .rd_err(rd_err), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_dim_m(rd_dim_m), .rd_dim_n(rd_dim_n), .busy(busy));

  // widened id so an out-of-range slot number can be requested
  matrix_store #(.ID_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .dim_m(dim_m), .dim_n(dim_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_abort(wr_abort), .rd_req(rd_req2), .rd_id(rd_id2), .commit(commit2), .commit_id(commit_id2),
    .mat_count(mat_count2), .dim_err(dim_err2), .rd_err(rd_err2), .rd_valid(rd_valid2), .rd_data(rd_data2),
    .rd_last(rd_last2), .rd_dim_m(rd_dim_m2), .rd_dim_n(rd_dim_n2), .busy(busy2));

  always #5 clk = ~clk;

  typedef struct {bit err; int data; bit last; int m; int n;} ritem_t;
  ritem_t rq[$];
  ritem_t r;
  int cq_id[$], cq_cnt[$];
  int dq = 0, e2q = 0;
  int md[8][25];
  bit mv[8];
  int mm[8], mn[8];
  int wp = 0, cnt = 0;
  int errors = 0, checks = 0, seen_valid = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (commit) begin
      chk("commit expected", int'(cq_id.size() != 0), 1);
      if (cq_id.size() != 0) begin
        chk("commit_id", int'(commit_id), cq_id.pop_front());
        chk("mat_count", int'(mat_count), cq_cnt.pop_front());
      end
    end
    if (dim_err) begin
      chk("dim_err expected", int'(dq > 0), 1);
      if (dq > 0) dq--;
    end
    if (rd_err2) begin
      chk("wide rd_err expected", int'(e2q > 0), 1);
      if (e2q > 0) e2q--;
    end
    if (rd_valid || rd_err) begin
      chk("read output expected", int'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("rd_err", int'(rd_err), int'(r.err));
        if (!r.err) begin
          chk("rd_data", int'(rd_data), r.data);
          chk("rd_last", int'(rd_last), int'(r.last));
          chk("rd_dim_m", int'(rd_dim_m), r.m);
          chk("rd_dim_n", int'(rd_dim_n), r.n);
        end
      end
    end
    if (rd_valid) seen_valid++;
  end

  task automatic step();
    @(posedge clk); #1;
    wr_en = 0; wr_abort = 0; rd_req = 0; rd_req2 = 0;
  endtask

  function automatic void exp_read(int id);
    ritem_t it;
    if (id >= 8 || !mv[id]) begin
      it.err = 1; it.data = 0; it.last = 0; it.m = 0; it.n = 0;
      rq.push_back(it);
    end else for (int e = 0; e < mm[id] * mn[id]; e++) begin
      it.err = 0; it.data = md[id][e]; it.last = e == mm[id] * mn[id] - 1; it.m = mm[id]; it.n = mn[id];
      rq.push_back(it);
    end
  endfunction

  task automatic write_matrix(int m, int n, int nel, bit abort, int base, int rd_at, int rid);
    int v[25];
    bit ok;
    ok = m >= 1 && m <= 5 && n >= 1 && n <= 5;
    for (int e = 0; e < 25; e++) v[e] = base >= 0 ? (base + e) & 255 : int'($urandom_range(255));
    if (!ok) begin
      dim_m = 3'(m); dim_n = 3'(n); wr_data = 8'(v[0]); wr_en = 1; dq++;
      step();
      return;
    end
    for (int e = 0; e < nel; e++) begin
      dim_m = e == 0 ? 3'(m) : 3'($urandom);
      dim_n = e == 0 ? 3'(n) : 3'($urandom);
      wr_data = 8'(v[e]); wr_en = 1;
      if (e == rd_at) begin rd_req = 1; rd_id = 3'(rid); end
      step();
      if (e < nel - 1 && $urandom_range(2) == 0) step();
    end
    if (abort) begin
      wr_abort = 1;
      mv[wp] = 0;
      step();
    end else begin
      for (int e = 0; e < 25; e++) md[wp][e] = v[e];
      mv[wp] = 1; mm[wp] = m; mn[wp] = n;
      cnt = cnt < 8 ? cnt + 1 : 8;
      cq_id.push_back(wp); cq_cnt.push_back(cnt);
      wp = (wp + 1) % 8;
    end
    if (rd_at >= 0) exp_read(rid);
  endtask

  task automatic do_read(int id);
    rd_req = 1; rd_id = 3'(id);
    exp_read(id);
    step();
  endtask

  task automatic wait_idle();
    int i = 0;
    while (i < 300 && (busy || rq.size() != 0 || cq_id.size() != 0 || dq != 0 || e2q != 0)) begin
      step();
      i++;
    end
    chk("drain within budget", int'(i < 300), 1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, " commit"}, int'(commit), 0);
    chk({tag, " commit_id"}, int'(commit_id), 0);
    chk({tag, " mat_count"}, int'(mat_count), 0);
    chk({tag, " rd_valid"}, int'(rd_valid), 0);
    chk({tag, " rd_data"}, int'(rd_data), 0);
    chk({tag, " rd_dims"}, int'({rd_dim_m, rd_dim_n}), 0);
    chk({tag, " flags"}, int'({dim_err, rd_err, rd_last}), 0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(); step();
    check_zero("reset");
    for (int s = 0; s < 8; s++) mv[s] = 0;
    wp = 0; cnt = 0;
    rq.delete(); cq_id.delete(); cq_cnt.delete(); dq = 0; e2q = 0;
    rst_n = 1;
    step();
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int a, b, m, n, tot, nel, rsel, v0, i;
    bit ab;
    do_reset();
    // 2x3 write and direct read with latency check
    write_matrix(2, 3, 6, 0, 1, -1, 0);
    wait_idle();
    do_read(0);
    @(posedge clk); #1;
    chk("latency k+1 rd_valid", int'(rd_valid), 0);
    @(posedge clk); #1;
    chk("latency k+2 rd_valid", int'(rd_valid), 1);
    chk("latency k+2 rd_data", int'(rd_data), 1);
    wait_idle();
    chk("t1 mat_count", int'(mat_count), 1);
    // illegal dims
    write_matrix(6, 3, 1, 0, 40, -1, 0);
    chk("t2 busy after dim_err", int'(busy), 0);
    write_matrix(2, 0, 1, 0, 50, -1, 0);
    wait_idle();
    chk("t2 busy", int'(busy), 0);
    chk("t2 mat_count", int'(mat_count), 1);
    // nine 1x1 matrices wrap the ring
    do_reset();
    for (int k = 0; k < 9; k++) write_matrix(1, 1, 1, 0, k + 1, -1, 0);
    wait_idle();
    chk("t3 mat_count", int'(mat_count), 8);
    chk("t3 wide mat_count", int'(mat_count2), 8);
    do_read(0);
    wait_idle();
    // empty slot and out-of-range id
    do_reset();
    write_matrix(2, 2, 4, 0, -1, -1, 0);
    wait_idle();
    do_read(5);
    wait_idle();
    rd_req2 = 1; rd_id2 = 4'd8; e2q++;
    step();
    wait_idle();
    // read requested mid-write of slot1 streams slot0 only after commit
    v0 = seen_valid;
    write_matrix(3, 3, 9, 0, -1, 2, 0);
    chk("t5 no stream before commit", seen_valid - v0, 0);
    wait_idle();
    // random mix
    for (int k = 0; k < 40; k++) begin
      rsel = int'($urandom_range(9));
      if (rsel < 6) begin
        m = int'($urandom_range(1, 5)); n = int'($urandom_range(1, 5));
        if (rsel == 0) m = $urandom_range(1) == 0 ? 0 : 6;
        tot = m * n;
        ab = rsel == 1 && tot > 1;
        nel = ab ? int'($urandom_range(1, tot - 1)) : tot;
        write_matrix(m, n, nel, ab, -1, (rsel == 2 || rsel == 3) ? int'($urandom_range(0, nel - 1)) : -1,
                     int'($urandom_range(7)));
      end else do_read(int'($urandom_range(7)));
      wait_idle();
    end
    // abort keeps wr_ptr; reset mid-read clears everything
    a = wp;
    write_matrix(3, 3, 4, 1, -1, -1, 0);
    wait_idle();
    do_read(a);
    wait_idle();
    write_matrix(1, 1, 1, 0, 77, -1, 0);
    wait_idle();
    b = wp;
    write_matrix(5, 5, 25, 0, -1, -1, 0);
    wait_idle();
    do_read(b);
    i = 0;
    while (i < 10 && !rd_valid) begin
      @(posedge clk); #1;
      i++;
    end
    chk("t6 stream started", int'(rd_valid), 1);
    chk("t6 busy mid-read", int'(busy), 1);
    #2 rst_n = 0;
    #1 check_zero("async reset");
    do_reset();
    do_read(0);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
